// File: rtl/cfu_cmd_sequencer.sv
// Purpose : CFU command initiator. Runs one GEMM job: RESET, SET_KMN, SET_OFFSET,
//           STORE_A/STORE_B (operands fetched from a sync source RAM), SET_VALID,
//           an IS_BUSY poll loop, then OUTPUT_C drain into a sink port.
// Ports   : start/kmn/offset/a_words/b_words/c_rows/b_base = job request (sampled on start);
//           src_rd/src_addr/src_data = source RAM; c_wr/c_addr/c_data = sink;
//           cmd_* / rsp_* = CFU valid-ready channels; busy/done/err = job status.
module cfu_cmd_sequencer #(
   parameter int ADDR_W   = 12,
   parameter int POLL_MAX = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [23:0]       kmn,
   input  logic [31:0]       offset,
   input  logic [ADDR_W-1:0] a_words,
   input  logic [ADDR_W-1:0] b_words,
   input  logic [ADDR_W-1:0] c_rows,
   input  logic [ADDR_W-1:0] b_base,
   output logic              src_rd,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [31:0]       src_data,
   output logic              c_wr,
   output logic [ADDR_W-1:0] c_addr,
   output logic [31:0]       c_data,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [9:0]        cmd_payload_function_id,
   output logic [31:0]       cmd_payload_inputs_0,
   output logic [31:0]       cmd_payload_inputs_1,
   input  logic              rsp_valid,
   output logic              rsp_ready,
   input  logic [31:0]       rsp_payload_outputs_0,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
   localparam logic [PW-1:0]     POLL_LIM = PW'(POLL_MAX);
   localparam logic [PW-1:0]     P_ONE    = 1;
   localparam logic [ADDR_W-1:0] A_ONE    = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      P_RESET, P_KMN, P_OFFSET, P_STORE_A, P_STORE_B, P_SET_VALID, P_IS_BUSY, P_OUTPUT_C
   } phase_t;

   state_t state, state_nxt;
   phase_t phase, phase_nxt;

   // Job parameters captured on start so the request inputs are free to change.
   logic [23:0]       kmn_q;
   logic [31:0]       offset_q;
   logic [ADDR_W-1:0] a_q, b_q, c_q, b_base_q;

   logic [ADDR_W-1:0] idx;       // operand index within STORE_A / STORE_B
   logic [ADDR_W-1:0] row;       // C row being drained
   logic [1:0]        lane;      // C lane within the row
   logic [PW-1:0]     poll_cnt;  // non-zero IS_BUSY responses seen
   logic [31:0]       data_q;    // fetched operand

   logic idx_last, row_last, poll_last, rsp_zero, rsp_hs;

   assign idx_last  = ((idx + A_ONE) == ((phase == P_STORE_A) ? a_q : b_q));
   assign row_last  = (lane == 2'd3) && ((row + A_ONE) == c_q);
   assign poll_last = ((poll_cnt + P_ONE) == POLL_LIM);
   assign rsp_zero  = (rsp_payload_outputs_0 == 32'd0);
   assign rsp_hs    = (state == S_WAIT) && rsp_valid;

   function automatic logic [6:0] funct7_of(input phase_t p);
      case (p)
         P_RESET:     funct7_of = 7'd0;
         P_KMN:       funct7_of = 7'd1;
         P_OFFSET:    funct7_of = 7'd6;
         P_STORE_A:   funct7_of = 7'd2;
         P_STORE_B:   funct7_of = 7'd3;
         P_SET_VALID: funct7_of = 7'd7;
         P_IS_BUSY:   funct7_of = 7'd4;
         P_OUTPUT_C:  funct7_of = 7'd5;
         default:     funct7_of = 7'd0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         phase <= P_RESET;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
      end
   end

   // Next state. Store phases go through FETCH/LOAD for every word; every
   // other command goes straight back to ISSUE after its response.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_ISSUE;
               phase_nxt = P_RESET;
            end
         end
         S_FETCH: state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (cmd_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (rsp_valid) begin
               state_nxt = S_ISSUE;
               case (phase)
                  P_RESET: phase_nxt = P_KMN;
                  P_KMN:   phase_nxt = P_OFFSET;
                  P_OFFSET: begin
                     if (a_q != '0) begin
                        phase_nxt = P_STORE_A;
                        state_nxt = S_FETCH;
                     end else if (b_q != '0) begin
                        phase_nxt = P_STORE_B;
                        state_nxt = S_FETCH;
                     end else begin
                        phase_nxt = P_SET_VALID;
                     end
                  end
                  P_STORE_A: begin
                     if (!idx_last) begin
                        state_nxt = S_FETCH;
                     end else if (b_q != '0) begin
                        phase_nxt = P_STORE_B;
                        state_nxt = S_FETCH;
                     end else begin
                        phase_nxt = P_SET_VALID;
                     end
                  end
                  P_STORE_B: begin
                     if (!idx_last) state_nxt = S_FETCH;
                     else           phase_nxt = P_SET_VALID;
                  end
                  P_SET_VALID: phase_nxt = P_IS_BUSY;
                  P_IS_BUSY: begin
                     if (rsp_zero) begin
                        if (c_q != '0) phase_nxt = P_OUTPUT_C;
                        else           state_nxt = S_DONE;
                     end else if (poll_last) begin
                        // CFU never went idle: give up without draining C.
                        state_nxt = S_DONE;
                     end
                  end
                  P_OUTPUT_C: begin
                     if (row_last) state_nxt = S_DONE;
                  end
                  default: state_nxt = S_DONE;
               endcase
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kmn_q    <= '0;
         offset_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         b_base_q <= '0;
         idx      <= '0;
         row      <= '0;
         lane     <= '0;
         poll_cnt <= '0;
         data_q   <= '0;
         err      <= 1'b0;
         c_wr     <= 1'b0;
         c_addr   <= '0;
         c_data   <= '0;
      end else begin
         c_wr <= 1'b0;
         if (state == S_IDLE && start) begin
            kmn_q    <= kmn;
            offset_q <= offset;
            a_q      <= a_words;
            b_q      <= b_words;
            c_q      <= c_rows;
            b_base_q <= b_base;
            idx      <= '0;
            row      <= '0;
            lane     <= '0;
            poll_cnt <= '0;
         end
         if (state == S_LOAD) data_q <= src_data;
         if (rsp_hs) begin
            case (phase)
               // idx returns to 0 on the last word so STORE_B starts fresh.
               P_STORE_A, P_STORE_B: idx <= idx_last ? '0 : idx + A_ONE;
               P_IS_BUSY: begin
                  if (!rsp_zero) begin
                     poll_cnt <= poll_cnt + P_ONE;
                     if (poll_last) err <= 1'b1;
                  end
               end
               P_OUTPUT_C: begin
                  c_wr   <= 1'b1;
                  c_data <= rsp_payload_outputs_0;
                  c_addr <= {row[ADDR_W-3:0], lane};
                  lane   <= lane + 2'd1;
                  if (lane == 2'd3) row <= row + A_ONE;
               end
               default: ;
            endcase
         end
      end
   end

   assign src_rd    = (state == S_FETCH);
   assign src_addr  = !src_rd ? '0 : (phase == P_STORE_A) ? idx : (b_base_q + idx);
   assign cmd_valid = (state == S_ISSUE);
   assign rsp_ready = (state == S_WAIT);
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);

   // Payload is a pure function of registered state, so it holds steady for
   // the whole ISSUE stall; it reads as zero outside ISSUE.
   always_comb begin
      cmd_payload_function_id = '0;
      cmd_payload_inputs_0    = '0;
      cmd_payload_inputs_1    = '0;
      if (state == S_ISSUE) begin
         cmd_payload_function_id = {funct7_of(phase), 3'b000};
         case (phase)
            P_KMN:      cmd_payload_inputs_0 = {8'h00, kmn_q};
            P_OFFSET:   cmd_payload_inputs_0 = offset_q;
            P_STORE_A:  cmd_payload_inputs_0 = data_q;
            P_STORE_B:  cmd_payload_inputs_1 = data_q;
            P_OUTPUT_C: cmd_payload_inputs_0 = {30'd0, lane};
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
module tb_cfu_cmd_sequencer;
   localparam int PM = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start;
   logic [23:0] kmn;
   logic [31:0] offset;
   logic [11:0] a_words, b_words, c_rows, b_base;
   logic        src_rd;
   logic [11:0] src_addr;
   logic [31:0] src_data;
   logic        c_wr;
   logic [11:0] c_addr;
   logic [31:0] c_data;
   logic        cmd_valid, cmd_ready;
   logic [9:0]  fid;
   logic [31:0] in0, in1;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic        busy, done, err;

   cfu_cmd_sequencer #(.ADDR_W(12), .POLL_MAX(PM)) dut (
      .clk(clk), .reset(reset), .start(start), .kmn(kmn), .offset(offset),
      .a_words(a_words), .b_words(b_words), .c_rows(c_rows), .b_base(b_base),
      .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
      .c_wr(c_wr), .c_addr(c_addr), .c_data(c_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_function_id(fid),
      .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_data),
      .busy(busy), .done(done), .err(err)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [4096];
   logic [73:0] cmd_log [$];
   logic [73:0] exp_cmd [$];
   logic [43:0] c_log [$];
   logic [43:0] exp_c [$];

   int          busy_cfg, polls_seen, c_seen, done_cnt;
   bit          stall;
   logic [31:0] seed;
   logic        exp_err;

   task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [73:0] mk(input int f7, input logic [31:0] a, input logic [31:0] b);
      return {f7[6:0], 3'b000, a, b};
   endfunction

   function automatic logic [31:0] cword(input int k);
      return 32'hC0DE0000 ^ (32'(k) * 32'h9E3779B1) ^ seed;
   endfunction

   // Sync source RAM: data appears the cycle after the read strobe.
   initial begin
      logic        rd;
      logic [11:0] ra;
      src_data = '0;
      forever begin
         @(negedge clk);
         rd = src_rd;
         ra = src_addr;
         @(posedge clk);
         #1;
         if (rd) src_data = mem[ra];
      end
   end

   // CFU responder: random cmd_ready and response latency, protocol checks.
   initial begin
      bit          rsp_pend, held_vld;
      int          rsp_dly;
      logic [31:0] pend_data;
      logic [73:0] held;
      rsp_pend = 0; held_vld = 0; rsp_dly = 0; pend_data = '0; held = '0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rsp_pend = 0; held_vld = 0;
            cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
         end else begin
            if (held_vld) begin
               chk("cmd_valid_held", 74'(cmd_valid), 74'(1));
               chk("payload_stable", {fid, in0, in1}, held);
            end
            if (cmd_valid) chk("one_outstanding", 74'(rsp_pend), 74'(0));
            rsp_valid = 1'b0;
            if (rsp_pend) begin
               if (rsp_dly != 0) rsp_dly--;
               else begin
                  rsp_valid = 1'b1;
                  rsp_data  = pend_data;
                  if (rsp_ready) rsp_pend = 0;
               end
            end
            cmd_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            held_vld  = cmd_valid && !cmd_ready;
            held      = {fid, in0, in1};
            if (cmd_valid && cmd_ready) begin
               cmd_log.push_back({fid, in0, in1});
               if (fid == 10'd32) begin
                  pend_data = (polls_seen < busy_cfg) ? (32'h1 | $urandom) : 32'h0;
                  polls_seen++;
               end else if (fid == 10'd40) begin
                  pend_data = cword(c_seen);
                  c_seen++;
               end else begin
                  pend_data = $urandom;
               end
               rsp_pend = 1;
               rsp_dly  = stall ? $urandom_range(0, 5) : 0;
            end
         end
      end
   end

   // Sink and done monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (c_wr) c_log.push_back({c_addr, c_data});
            if (done) begin
               done_cnt++;
               chk("busy_low_at_done", 74'(busy), 74'(0));
            end
         end
      end
   end

   task automatic run_job(input logic [23:0] k, input logic [31:0] off, input int na, input int nb,
                          input int nc, input logic [11:0] bb, input int nbusy, input bit stl,
                          input bit inj, input string name);
      int polls, guard, n;
      bit to;
      seed = $urandom;
      exp_cmd.delete();
      exp_c.delete();
      exp_cmd.push_back(mk(0, 0, 0));
      exp_cmd.push_back(mk(1, {8'h00, k}, 0));
      exp_cmd.push_back(mk(6, off, 0));
      for (int i = 0; i < na; i++) exp_cmd.push_back(mk(2, mem[i], 0));
      for (int j = 0; j < nb; j++) exp_cmd.push_back(mk(3, 0, mem[bb + 12'(j)]));
      exp_cmd.push_back(mk(7, 0, 0));
      to    = (nbusy >= PM);
      polls = to ? PM : nbusy + 1;
      for (int p = 0; p < polls; p++) exp_cmd.push_back(mk(4, 0, 0));
      if (!to) begin
         for (int w = 0; w < nc * 4; w++) begin
            exp_cmd.push_back(mk(5, 32'(w % 4), 0));
            exp_c.push_back({12'(w), cword(w)});
         end
      end
      exp_err = exp_err | to;

      cmd_log.delete(); c_log.delete();
      done_cnt = 0; busy_cfg = nbusy; polls_seen = 0; c_seen = 0; stall = stl;
      @(negedge clk);
      kmn = k; offset = off; a_words = 12'(na); b_words = 12'(nb); c_rows = 12'(nc);
      b_base = bb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      kmn = $urandom; offset = $urandom; a_words = $urandom; b_words = $urandom;
      c_rows = $urandom; b_base = $urandom;
      chk({name, ":busy_after_start"}, 74'(busy), 74'(1));
      if (inj) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (guard = 0; guard < 20000 && done_cnt == 0; guard++) @(negedge clk);
      chk({name, ":done_seen"}, 74'(done_cnt != 0), 74'(1));
      repeat (3) @(negedge clk);
      chk({name, ":done_once"}, 74'(done_cnt), 74'(1));
      chk({name, ":busy_idle"}, 74'(busy), 74'(0));
      chk({name, ":err"}, 74'(err), 74'(exp_err));
      chk({name, ":n_cmds"}, 74'(cmd_log.size()), 74'(exp_cmd.size()));
      n = (cmd_log.size() < exp_cmd.size()) ? cmd_log.size() : exp_cmd.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s:cmd%0d", name, i), cmd_log[i], exp_cmd[i]);
      chk({name, ":n_cwr"}, 74'(c_log.size()), 74'(exp_c.size()));
      n = (c_log.size() < exp_c.size()) ? c_log.size() : exp_c.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s:c%0d", name, i), 74'(c_log[i]), 74'(exp_c[i]));
   endtask

   initial begin
      int guard;
      reset = 1'b1; start = 1'b0; kmn = '0; offset = '0;
      a_words = '0; b_words = '0; c_rows = '0; b_base = '0;
      exp_err = 1'b0; done_cnt = 0; busy_cfg = 0; polls_seen = 0; c_seen = 0;
      stall = 0; seed = '0;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      repeat (3) @(negedge clk);
      chk("rst:status", 74'({cmd_valid, rsp_ready, src_rd, c_wr, busy, done, err}), 74'(0));
      chk("rst:payload", {fid, in0, in1}, 74'(0));
      chk("rst:sink", 74'({c_addr, c_data, src_addr}), 74'(0));
      reset = 1'b0;

      run_job(24'h040404, 32'd128, 4, 4, 4, 12'd4, 10, 0, 0, "s1");
      run_job(24'h040404, 32'd128, 4, 4, 4, 12'd4, 10, 1, 0, "s2_stall");
      run_job(24'h010203, 32'hDEAD0001, 0, 2, 1, 12'd300, 2, 1, 0, "s3_no_a");
      run_job(24'h0A0B0C, 32'h11, 2, 1, 2, 12'd50, PM - 1, 1, 0, "poll_edge");
      run_job(24'h020202, 32'h22, 1, 1, 2, 12'd9, 1000, 1, 0, "timeout");
      run_job(24'h030303, 32'h33, 1, 1, 1, 12'd7, 0, 0, 0, "err_sticky");

      // Reset in the middle of STORE_B aborts the job and clears err.
      cmd_log.delete(); busy_cfg = 3; polls_seen = 0; c_seen = 0; stall = 1;
      @(negedge clk);
      a_words = 12'd3; b_words = 12'd5; c_rows = 12'd2; b_base = 12'd100;
      kmn = 24'h050505; offset = 32'h5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (guard = 0; guard < 5000 && !(cmd_valid && fid == 10'd24); guard++) @(negedge clk);
      chk("mid_rst:in_store_b", 74'(cmd_valid && fid == 10'd24), 74'(1));
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst:outputs", 74'({cmd_valid, rsp_ready, busy, err, src_rd}), 74'(0));
      @(negedge clk);
      reset = 1'b0;
      exp_err = 1'b0;

      run_job(24'h040404, 32'd128, 4, 4, 4, 12'd4, 10, 1, 0, "after_rst");
      run_job(24'h123456, 32'hCAFEF00D, 3, 2, 2, 12'd20, 1, 1, 1, "start_busy");
      run_job(24'h0F0F0F, 32'h44, 0, 4, 1, 12'd4094, 0, 1, 0, "b_wrap");
      run_job(24'h000001, 32'h55, 0, 0, 0, 12'd0, 0, 0, 0, "all_zero");
      for (int r = 0; r < 8; r++)
         run_job(24'($urandom), $urandom, $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 3), 12'($urandom), $urandom_range(0, PM + 2), 1, r[0],
                 $sformatf("rnd%0d", r));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
